// File: rtl/fma_issue_arbiter.sv
// Round-robin issue arbiter sharing one pipelined FMA unit between two requesters,
// with credit-guarded response FIFOs. Optional protocol checker: FMA_ISSUE_ARBITER_CHECK_EN.
module fma_issue_arbiter #(
  parameter int LATENCY    = 4,
  parameter int RESP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [64:0] req0_a,
  input  logic [64:0] req0_b,
  input  logic [64:0] req0_c,
  input  logic [1:0]  req0_op,
  input  logic [2:0]  req0_rm,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [64:0] req1_a,
  input  logic [64:0] req1_b,
  input  logic [64:0] req1_c,
  input  logic [1:0]  req1_op,
  input  logic [2:0]  req1_rm,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [64:0] resp0_out,
  output logic [4:0]  resp0_flags,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [64:0] resp1_out,
  output logic [4:0]  resp1_flags,
  output logic        fma_validin,
  output logic [64:0] fma_a,
  output logic [64:0] fma_b,
  output logic [64:0] fma_c,
  output logic [1:0]  fma_op,
  output logic [2:0]  fma_rm,
  input  logic        fma_validout,
  input  logic [64:0] fma_out,
  input  logic [4:0]  fma_flags,
  output logic        busy,
  output logic        err
);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(RESP_DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [PW-1:0] PTR_LAST = PW'(RESP_DEPTH - 1);

  logic [1:0]         elig_s, win_s, push_s, pop_s, resp_ready_s;
  logic               retire_s;
  logic               prio_q, prio_d;
  logic [CW-1:0]      credit_q [2];
  logic [CW-1:0]      credit_d [2];
  logic [CW-1:0]      count_q  [2];
  logic [CW-1:0]      count_d  [2];
  logic [PW-1:0]      wr_ptr_q [2];
  logic [PW-1:0]      wr_ptr_d [2];
  logic [PW-1:0]      rd_ptr_q [2];
  logic [PW-1:0]      rd_ptr_d [2];
  logic [69:0]        mem_q [2][RESP_DEPTH];
  logic [69:0]        mem_d [2][RESP_DEPTH];
  logic               fma_validin_q, fma_validin_d, fma_id_q, fma_id_d;
  logic [64:0]        fma_a_q, fma_a_d, fma_b_q, fma_b_d, fma_c_q, fma_c_d;
  logic [1:0]         fma_op_q, fma_op_d;
  logic [2:0]         fma_rm_q, fma_rm_d;
  logic [LATENCY-1:0] tag_v_q, tag_v_d, tag_id_q, tag_id_d;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PTR_LAST) next_ptr = {PW{1'b0}};
    else               next_ptr = p + PW'(1'b1);
  endfunction

  assign resp_ready_s = {resp1_ready, resp0_ready};

  always_comb begin
    elig_s[0] = req0_valid & (credit_q[0] != CNT_ZERO);
    elig_s[1] = req1_valid & (credit_q[1] != CNT_ZERO);
    win_s[0]  = elig_s[0] & (~elig_s[1] | ~prio_q);
    win_s[1]  = elig_s[1] & (~elig_s[0] |  prio_q);
    if (win_s[0])      prio_d = 1'b1;
    else if (win_s[1]) prio_d = 1'b0;
    else               prio_d = prio_q;
  end

  // Ready is held low while reset is asserted even though credits already read full.
  assign req0_ready = win_s[0] & rst_n;
  assign req1_ready = win_s[1] & rst_n;

  always_comb begin
    fma_validin_d = win_s[0] | win_s[1];
    fma_id_d = fma_id_q;
    fma_a_d  = fma_a_q;
    fma_b_d  = fma_b_q;
    fma_c_d  = fma_c_q;
    fma_op_d = fma_op_q;
    fma_rm_d = fma_rm_q;
    if (win_s[1]) begin
      fma_id_d = 1'b1; fma_a_d = req1_a; fma_b_d = req1_b; fma_c_d = req1_c;
      fma_op_d = req1_op; fma_rm_d = req1_rm;
    end else if (win_s[0]) begin
      fma_id_d = 1'b0; fma_a_d = req0_a; fma_b_d = req0_b; fma_c_d = req0_c;
      fma_op_d = req0_op; fma_rm_d = req0_rm;
    end else begin
      fma_id_d = fma_id_q;
    end
  end

  // Tag pipe follows the issue register, so its last stage lines up with fma_validout.
  always_comb begin
    tag_v_d  = tag_v_q;
    tag_id_d = tag_id_q;
    tag_v_d[0]  = fma_validin_q;
    tag_id_d[0] = fma_id_q;
    for (int i = 1; i < LATENCY; i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end
  end

  assign retire_s = tag_v_q[LATENCY-1];

  always_comb begin
    mem_d = mem_q;
    for (int n = 0; n < 2; n++) begin
      push_s[n]   = retire_s & (tag_id_q[LATENCY-1] == 1'(n));
      pop_s[n]    = (count_q[n] != CNT_ZERO) & resp_ready_s[n];
      wr_ptr_d[n] = wr_ptr_q[n];
      rd_ptr_d[n] = rd_ptr_q[n];
      if (push_s[n]) begin
        mem_d[n][wr_ptr_q[n]] = {fma_flags, fma_out};
        wr_ptr_d[n] = next_ptr(wr_ptr_q[n]);
      end else begin
        wr_ptr_d[n] = wr_ptr_q[n];
      end
      if (pop_s[n]) rd_ptr_d[n] = next_ptr(rd_ptr_q[n]);
      else          rd_ptr_d[n] = rd_ptr_q[n];
      case ({push_s[n], pop_s[n]})
        2'b10:   count_d[n] = count_q[n] + CNT_ONE;
        2'b01:   count_d[n] = count_q[n] - CNT_ONE;
        default: count_d[n] = count_q[n];
      endcase
      case ({win_s[n], pop_s[n]})
        2'b10:   credit_d[n] = credit_q[n] - CNT_ONE;
        2'b01:   credit_d[n] = credit_q[n] + CNT_ONE;
        default: credit_d[n] = credit_q[n];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q        <= 1'b0;
      fma_validin_q <= 1'b0;
      fma_id_q      <= 1'b0;
      fma_a_q       <= 65'd0;
      fma_b_q       <= 65'd0;
      fma_c_q       <= 65'd0;
      fma_op_q      <= 2'd0;
      fma_rm_q      <= 3'd0;
      tag_v_q       <= {LATENCY{1'b0}};
      tag_id_q      <= {LATENCY{1'b0}};
      for (int n = 0; n < 2; n++) begin
        credit_q[n] <= CNT_MAX;
        count_q[n]  <= CNT_ZERO;
        wr_ptr_q[n] <= {PW{1'b0}};
        rd_ptr_q[n] <= {PW{1'b0}};
        for (int e = 0; e < RESP_DEPTH; e++) mem_q[n][e] <= 70'd0;
      end
    end else begin
      prio_q        <= prio_d;
      fma_validin_q <= fma_validin_d;
      fma_id_q      <= fma_id_d;
      fma_a_q       <= fma_a_d;
      fma_b_q       <= fma_b_d;
      fma_c_q       <= fma_c_d;
      fma_op_q      <= fma_op_d;
      fma_rm_q      <= fma_rm_d;
      tag_v_q       <= tag_v_d;
      tag_id_q      <= tag_id_d;
      credit_q      <= credit_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_q         <= mem_d;
    end
  end

`ifdef FMA_ISSUE_ARBITER_CHECK_EN
  logic err_q, err_d;

  // Any strobe/tag disagreement latches the error until reset; untagged strobes never retire.
  always_comb begin
    if (fma_validout != tag_v_q[LATENCY-1]) err_d = 1'b1;
    else                                    err_d = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_validout_s;
  assign unused_validout_s = fma_validout;
  assign err = 1'b0;
`endif

  assign fma_validin = fma_validin_q;
  assign fma_a       = fma_a_q;
  assign fma_b       = fma_b_q;
  assign fma_c       = fma_c_q;
  assign fma_op      = fma_op_q;
  assign fma_rm      = fma_rm_q;
  assign resp0_valid = (count_q[0] != CNT_ZERO);
  assign resp1_valid = (count_q[1] != CNT_ZERO);
  assign resp0_out   = mem_q[0][rd_ptr_q[0]][64:0];
  assign resp0_flags = mem_q[0][rd_ptr_q[0]][69:65];
  assign resp1_out   = mem_q[1][rd_ptr_q[1]][64:0];
  assign resp1_flags = mem_q[1][rd_ptr_q[1]][69:65];
  assign busy = fma_validin_q | (|tag_v_q) | resp0_valid | resp1_valid;
endmodule
